// File: rtl/alarm_time_setter.sv
// Button-driven editor that produces BCD hour/minute load values and load strobes for the alarm clock core.
// Defining AUTO_REPEAT_EN adds hold-to-repeat on btn_inc.
module alarm_time_setter #(
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 100,
  parameter int REPEAT_DLY  = 5,
  parameter int REPEAT_RATE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set_time,
  input  logic       btn_set_alarm,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_cancel,
  input  logic [1:0] H_out1,
  input  logic [3:0] H_out0,
  input  logic [3:0] M_out1,
  input  logic [3:0] M_out0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic       edit_field
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int LC_W = $clog2(LOAD_CYCLES + 1);

  if ((LOAD_CYCLES < 1) || (TIMEOUT < 2) || (REPEAT_DLY < 1) || (REPEAT_RATE < 1)) begin : g_param_check
    $error("alarm_time_setter: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EDIT_HR  = 2'd1,
    S_EDIT_MIN = 2'd2,
    S_LOAD     = 2'd3
  } state_t;

  state_t            r_state, w_next_state;
  logic [4:0]        r_btn_prev;
  logic [4:0]        w_btn, w_edge;
  logic [1:0]        r_h1;
  logic [3:0]        r_h0, r_m1, r_m0;
  logic [13:0]       r_shadow;
  logic              r_target;
  logic [TO_W-1:0]   r_to_cnt;
  logic [LC_W-1:0]   r_load_cnt;
  logic              r_ld_time, r_ld_alarm, r_editing, r_edit_field;
  logic              w_seed_time, w_seed_alarm, w_inc_hr, w_inc_min, w_clr_to, w_commit;
  logic              w_rep;
  logic              w_next_edit;

  function automatic logic [5:0] f_hour_inc(input logic [1:0] h1, input logic [3:0] h0);
    logic [5:0] v;
    if ((h1 > 2'd2) || ((h1 == 2'd2) && (h0 >= 4'd3))) v = 6'd0;
    else if (h0 >= 4'd9) v = {h1 + 2'd1, 4'd0};
    else v = {h1, h0 + 4'd1};
    return v;
  endfunction

  function automatic logic [7:0] f_min_inc(input logic [3:0] m1, input logic [3:0] m0);
    logic [7:0] v;
    if (m0 >= 4'd9) begin
      if (m1 >= 4'd5) v = 8'd0;
      else v = {m1 + 4'd1, 4'd0};
    end else begin
      v = {m1, m0 + 4'd1};
    end
    return v;
  endfunction

  // bit order: cancel, next, inc, set_time, set_alarm
  assign w_btn       = {btn_cancel, btn_next, btn_inc, btn_set_time, btn_set_alarm};
  assign w_edge      = w_btn & ~r_btn_prev;
  assign w_next_edit = (w_next_state == S_EDIT_HR) || (w_next_state == S_EDIT_MIN);

`ifdef AUTO_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_DLY + REPEAT_RATE + 1);
  logic [RP_W-1:0] r_rep_cnt;
  logic            r_rep_act, r_rep_started;
  logic            w_in_edit;
  logic [RP_W-1:0] w_rep_thr;

  assign w_in_edit = (r_state == S_EDIT_HR) || (r_state == S_EDIT_MIN);
  assign w_rep_thr = r_rep_started ? RP_W'(REPEAT_RATE) : RP_W'(REPEAT_DLY);
  assign w_rep     = r_rep_act & btn_inc & w_in_edit & (r_rep_cnt == w_rep_thr);

  // Hold counter: first threshold is REPEAT_DLY after the edge, then REPEAT_RATE between repeats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rep_cnt     <= '0;
      r_rep_act     <= 1'b0;
      r_rep_started <= 1'b0;
    end else if (w_in_edit && w_edge[2] && !w_edge[4] && !w_edge[3]) begin
      r_rep_cnt     <= RP_W'(1);
      r_rep_act     <= 1'b1;
      r_rep_started <= 1'b0;
    end else if (r_rep_act && btn_inc && w_in_edit && (w_next_state == r_state)) begin
      if (w_rep) begin
        r_rep_cnt     <= RP_W'(1);
        r_rep_started <= 1'b1;
      end else begin
        r_rep_cnt     <= r_rep_cnt + RP_W'(1);
      end
    end else begin
      r_rep_cnt     <= '0;
      r_rep_act     <= 1'b0;
      r_rep_started <= 1'b0;
    end
  end
`else
  assign w_rep = 1'b0;
`endif

  // State register and button history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_btn_prev <= 5'b11111;
    end else begin
      r_state    <= w_next_state;
      r_btn_prev <= w_btn;
    end
  end

  // Next-state and action decode; one edge acts per cycle, cancel > next > inc > set_time > set_alarm.
  always_comb begin
    w_next_state = r_state;
    w_seed_time  = 1'b0;
    w_seed_alarm = 1'b0;
    w_inc_hr     = 1'b0;
    w_inc_min    = 1'b0;
    w_clr_to     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_edge[1]) begin
          w_next_state = S_EDIT_HR;
          w_seed_time  = 1'b1;
        end else if (w_edge[0]) begin
          w_next_state = S_EDIT_HR;
          w_seed_alarm = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_EDIT_HR: begin
        if (w_edge[4]) begin
          w_next_state = S_IDLE;
        end else if (w_edge[3]) begin
          w_next_state = S_EDIT_MIN;
        end else if (w_edge[2] || w_rep) begin
          w_inc_hr = 1'b1;
          w_clr_to = 1'b1;
        end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_EDIT_HR;
        end
      end
      S_EDIT_MIN: begin
        if (w_edge[4]) begin
          w_next_state = S_IDLE;
        end else if (w_edge[3]) begin
          w_next_state = S_LOAD;
        end else if (w_edge[2] || w_rep) begin
          w_inc_min = 1'b1;
          w_clr_to  = 1'b1;
        end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_EDIT_MIN;
        end
      end
      S_LOAD: begin
        if (r_load_cnt == LC_W'(LOAD_CYCLES - 1)) begin
          w_next_state = S_IDLE;
          w_commit     = 1'b1;
        end else begin
          w_next_state = S_LOAD;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Idle timeout and strobe-length counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt   <= '0;
      r_load_cnt <= '0;
    end else begin
      if (w_next_edit && ((w_next_state != r_state) || w_clr_to)) r_to_cnt <= '0;
      else if (w_next_edit) r_to_cnt <= r_to_cnt + TO_W'(1);
      else r_to_cnt <= '0;
      if ((r_state == S_LOAD) && (w_next_state == S_LOAD)) r_load_cnt <= r_load_cnt + LC_W'(1);
      else r_load_cnt <= '0;
    end
  end

  // Edit registers, load target and committed-alarm shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h1     <= 2'd0;
      r_h0     <= 4'd0;
      r_m1     <= 4'd0;
      r_m0     <= 4'd0;
      r_target <= 1'b0;
      r_shadow <= 14'd0;
    end else begin
      if (w_seed_time) begin
        {r_h1, r_h0, r_m1, r_m0} <= {H_out1, H_out0, M_out1, M_out0};
        r_target                 <= 1'b0;
      end else if (w_seed_alarm) begin
        {r_h1, r_h0, r_m1, r_m0} <= r_shadow;
        r_target                 <= 1'b1;
      end else if (w_inc_hr) begin
        {r_h1, r_h0} <= f_hour_inc(r_h1, r_h0);
      end else if (w_inc_min) begin
        {r_m1, r_m0} <= f_min_inc(r_m1, r_m0);
      end else begin
        {r_h1, r_h0, r_m1, r_m0} <= {r_h1, r_h0, r_m1, r_m0};
      end
      if (w_commit && r_target) r_shadow <= {r_h1, r_h0, r_m1, r_m0};
      else r_shadow <= r_shadow;
    end
  end

  // Registered status outputs and strobes, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_time    <= 1'b0;
      r_ld_alarm   <= 1'b0;
      r_editing    <= 1'b0;
      r_edit_field <= 1'b0;
    end else begin
      r_ld_time    <= (w_next_state == S_LOAD) && !r_target;
      r_ld_alarm   <= (w_next_state == S_LOAD) && r_target;
      r_editing    <= w_next_edit;
      r_edit_field <= (w_next_state == S_EDIT_MIN);
    end
  end

  assign H_in1      = r_h1;
  assign H_in0      = r_h0;
  assign M_in1      = r_m1;
  assign M_in0      = r_m0;
  assign LD_time    = r_ld_time;
  assign LD_alarm   = r_ld_alarm;
  assign editing    = r_editing;
  assign edit_field = r_edit_field;

endmodule

// File: tb/tb_alarm_time_setter.sv
// Scoreboard bench for alarm_time_setter: commits push expected loads, strobe observation pops and compares.
module tb_alarm_time_setter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_set_time = 1'b0, btn_set_alarm = 1'b0, btn_inc = 1'b0, btn_next = 1'b0, btn_cancel = 1'b0;
  logic [1:0] H_out1 = 2'd0;
  logic [3:0] H_out0 = 4'd0, M_out1 = 4'd0, M_out0 = 4'd0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, editing, edit_field;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_h, exp_m;

  typedef struct packed {
    logic        tgt;
    logic [13:0] val;
  } exp_t;
  exp_t sb_q[$];

  alarm_time_setter #(.LOAD_CYCLES(2), .TIMEOUT(100), .REPEAT_DLY(5), .REPEAT_RATE(2)) dut (
    .clk(clk), .reset(reset),
    .btn_set_time(btn_set_time), .btn_set_alarm(btn_set_alarm), .btn_inc(btn_inc),
    .btn_next(btn_next), .btn_cancel(btn_cancel),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .editing(editing), .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] to_bcd(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // b: 0 set_alarm, 1 set_time, 2 inc, 3 next, 4 cancel
  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_set_alarm = v;
      1: btn_set_time  = v;
      2: btn_inc       = v;
      3: btn_next      = v;
      default: btn_cancel = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick();
    set_btn(b, 1'b0);
    tick();
  endtask

  task automatic set_clock(input int h, input int m);
    {H_out1, H_out0, M_out1, M_out0} = to_bcd(h, m);
  endtask

  // Watch the strobes for a bounded window starting right after the committing edge.
  task automatic observe_commit(output int first, output int hi_t, output int hi_a, output int both,
                                output logic [13:0] val);
    first = -1; hi_t = 0; hi_a = 0; both = 0; val = 14'd0;
    for (int c = 0; c < 8; c++) begin
      if (LD_time || LD_alarm) begin
        if (first < 0) begin
          first = c;
          val   = {H_in1, H_in0, M_in1, M_in0};
        end
        if (LD_time) hi_t++;
        if (LD_alarm) hi_a++;
        if (LD_time && LD_alarm) both++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_set_time = 1'b1; btn_set_alarm = 1'b1; btn_inc = 1'b1; btn_next = 1'b1; btn_cancel = 1'b1;
    set_clock(10, 19);
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
    n_checks++;
    if ({editing, edit_field} !== 2'b00) begin
      n_fail++; $display("FAIL reset_status: got %b expected 00", {editing, edit_field});
    end
    n_checks++;
    if ({LD_time, LD_alarm} !== 2'b00) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 00", {LD_time, LD_alarm});
    end
    n_checks++;
    if ({H_in1, H_in0, M_in1, M_in0} !== 14'd0) begin
      n_fail++; $display("FAIL reset_values: got %h expected 0", {H_in1, H_in0, M_in1, M_in0});
    end
    btn_set_time = 1'b0; btn_set_alarm = 1'b0; btn_inc = 1'b0; btn_next = 1'b0; btn_cancel = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (editing !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_editing: got %b expected 0", editing);
    end
  endtask

  task automatic test_set_time();
    int first, hi_t, hi_a, both;
    logic [13:0] val;
    exp_t e;
    set_clock(10, 19);
    exp_h = 10; exp_m = 19;
    press(1);
    n_checks++;
    if ({editing, edit_field, H_in1, H_in0, M_in1, M_in0} !== {2'b10, to_bcd(exp_h, exp_m)}) begin
      n_fail++; $display("FAIL time_seed: got %b/%h expected 10/%h", {editing, edit_field},
                         {H_in1, H_in0, M_in1, M_in0}, to_bcd(exp_h, exp_m));
    end
    repeat (3) press(2);
    exp_h = (exp_h + 3) % 24;
    n_checks++;
    if ({H_in1, H_in0} !== to_bcd(exp_h, 0) >> 8) begin
      n_fail++; $display("FAIL time_hour_inc: got %h expected 13", {H_in1, H_in0});
    end
    press(3);
    n_checks++;
    if (edit_field !== 1'b1) begin
      n_fail++; $display("FAIL time_field_adv: got %b expected 1", edit_field);
    end
    repeat (2) press(2);
    exp_m = (exp_m + 2) % 60;
    btn_next = 1'b1;
    sb_q.push_back('{tgt: 1'b0, val: to_bcd(exp_h, exp_m)});
    tick();
    btn_next = 1'b0;
    observe_commit(first, hi_t, hi_a, both, val);
    e = sb_q.pop_front();
    n_checks++;
    if (first !== 0) begin
      n_fail++; $display("FAIL time_strobe_start: got cycle %0d expected 0", first);
    end
    n_checks++;
    if (val !== e.val) begin
      n_fail++; $display("FAIL time_load_value: got %h expected %h", val, e.val);
    end
    n_checks++;
    if ({hi_t, hi_a} !== {(e.tgt ? 0 : 2), (e.tgt ? 2 : 0)}) begin
      n_fail++; $display("FAIL time_strobe_len: got time=%0d alarm=%0d expected time=2 alarm=0", hi_t, hi_a);
    end
    set_clock(7, 45);
    repeat (3) tick();
    n_checks++;
    if ({editing, H_in1, H_in0, M_in1, M_in0} !== {1'b0, e.val}) begin
      n_fail++; $display("FAIL time_hold_idle: got %b/%h expected 0/%h", editing, {H_in1, H_in0, M_in1, M_in0}, e.val);
    end
  endtask

  task automatic test_set_alarm();
    int first, hi_t, hi_a, both;
    logic [13:0] val;
    exp_t e;
    int strobes;
    exp_h = 0; exp_m = 0;
    press(0);
    n_checks++;
    if ({editing, H_in1, H_in0, M_in1, M_in0} !== {1'b1, to_bcd(exp_h, exp_m)}) begin
      n_fail++; $display("FAIL alarm_seed: got %b/%h expected 1/%h", editing, {H_in1, H_in0, M_in1, M_in0}, to_bcd(exp_h, exp_m));
    end
    for (int i = 0; i < 23; i++) begin
      press(2);
      exp_h = (exp_h + 1) % 24;
      n_checks++;
      if ({H_in1, H_in0, M_in1, M_in0} !== to_bcd(exp_h, exp_m)) begin
        n_fail++; $display("FAIL alarm_hour_walk: got %h expected %h", {H_in1, H_in0, M_in1, M_in0}, to_bcd(exp_h, exp_m));
      end
    end
    press(3);
    for (int i = 0; i < 60; i++) begin
      press(2);
      exp_m = (exp_m + 1) % 60;
      n_checks++;
      if ({H_in1, H_in0, M_in1, M_in0} !== to_bcd(exp_h, exp_m)) begin
        n_fail++; $display("FAIL alarm_min_walk: got %h expected %h", {H_in1, H_in0, M_in1, M_in0}, to_bcd(exp_h, exp_m));
      end
    end
    btn_next = 1'b1;
    sb_q.push_back('{tgt: 1'b1, val: to_bcd(exp_h, exp_m)});
    tick();
    btn_next = 1'b0;
    observe_commit(first, hi_t, hi_a, both, val);
    e = sb_q.pop_front();
    n_checks++;
    if ((first !== 0) || (val !== e.val)) begin
      n_fail++; $display("FAIL alarm_load: got cycle %0d value %h expected cycle 0 value %h", first, val, e.val);
    end
    n_checks++;
    if ({hi_t, hi_a, both} !== {(e.tgt ? 0 : 2), (e.tgt ? 2 : 0), 0}) begin
      n_fail++; $display("FAIL alarm_strobe_len: got time=%0d alarm=%0d both=%0d expected time=0 alarm=2 both=0", hi_t, hi_a, both);
    end
    press(0);
    n_checks++;
    if ({H_in1, H_in0, M_in1, M_in0} !== e.val) begin
      n_fail++; $display("FAIL alarm_reseed: got %h expected %h", {H_in1, H_in0, M_in1, M_in0}, e.val);
    end
    press(2);
    n_checks++;
    if ({H_in1, H_in0} !== 6'd0) begin
      n_fail++; $display("FAIL hour_wrap_23: got %h expected 00", {H_in1, H_in0});
    end
    strobes = 0;
    btn_cancel = 1'b1;
    tick();
    btn_cancel = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (LD_time || LD_alarm) strobes++;
      tick();
    end
    n_checks++;
    if ({editing, 32'(strobes)} !== {1'b0, 32'd0}) begin
      n_fail++; $display("FAIL cancel: got editing=%b strobes=%0d expected editing=0 strobes=0", editing, strobes);
    end
    press(0);
    n_checks++;
    if ({H_in1, H_in0, M_in1, M_in0} !== e.val) begin
      n_fail++; $display("FAIL cancel_keeps_shadow: got %h expected %h", {H_in1, H_in0, M_in1, M_in0}, e.val);
    end
    press(4);
  endtask

  task automatic test_timeout();
    int strobes = 0;
    set_clock(8, 30);
    btn_set_time = 1'b1;
    tick();
    btn_set_time = 1'b0;
    for (int c = 0; c < 99; c++) begin
      tick();
      if (LD_time || LD_alarm) strobes++;
    end
    n_checks++;
    if (editing !== 1'b1) begin
      n_fail++; $display("FAIL timeout_early: got editing=%b expected 1 after 99 cycles", editing);
    end
    tick();
    if (LD_time || LD_alarm) strobes++;
    n_checks++;
    if (editing !== 1'b0) begin
      n_fail++; $display("FAIL timeout_exit: got editing=%b expected 0 after 100 cycles", editing);
    end
    n_checks++;
    if ({strobes, H_in1, H_in0, M_in1, M_in0} !== {32'd0, to_bcd(8, 30)}) begin
      n_fail++; $display("FAIL timeout_no_load: got strobes=%0d value %h expected 0 and %h", strobes, {H_in1, H_in0, M_in1, M_in0}, to_bcd(8, 30));
    end
  endtask

  task automatic test_same_cycle();
    set_clock(5, 30);
    press(1);
    btn_next = 1'b1;
    btn_inc  = 1'b1;
    tick();
    btn_next = 1'b0;
    btn_inc  = 1'b0;
    tick();
    n_checks++;
    if ({edit_field, H_in1, H_in0, M_in1, M_in0} !== {1'b1, to_bcd(5, 30)}) begin
      n_fail++; $display("FAIL next_beats_inc: got %b/%h expected 1/%h", edit_field, {H_in1, H_in0, M_in1, M_in0}, to_bcd(5, 30));
    end
    press(4);
  endtask

  task automatic test_reset_in_load();
    press(0);
    press(3);
    press(2);
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    n_checks++;
    if (LD_alarm !== 1'b1) begin
      n_fail++; $display("FAIL load_before_reset: got LD_alarm=%b expected 1", LD_alarm);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({LD_time, LD_alarm, editing} !== 3'b000) begin
      n_fail++; $display("FAIL reset_in_load: got %b expected 000", {LD_time, LD_alarm, editing});
    end
    reset = 1'b0;
    tick();
    press(0);
    n_checks++;
    if ({editing, H_in1, H_in0, M_in1, M_in0} !== {1'b1, 14'd0}) begin
      n_fail++; $display("FAIL shadow_cleared: got %b/%h expected 1/0000", editing, {H_in1, H_in0, M_in1, M_in0});
    end
    press(4);
  endtask

  task automatic test_auto_repeat();
    int exp_min;
`ifdef AUTO_REPEAT_EN
    exp_min = 6;
`else
    exp_min = 1;
`endif
    set_clock(0, 0);
    press(1);
    press(3);
    btn_inc = 1'b1;
    repeat (15) tick();
    btn_inc = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({editing, edit_field, H_in1, H_in0, M_in1, M_in0} !== {2'b11, to_bcd(0, exp_min)}) begin
      n_fail++; $display("FAIL hold_inc: got %b/%h expected 11/%h", {editing, edit_field}, {H_in1, H_in0, M_in1, M_in0}, to_bcd(0, exp_min));
    end
    press(4);
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_set_alarm();
    test_timeout();
    test_same_cycle();
    test_reset_in_load();
    test_auto_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
